tbird_seq_ctrl: RTL and testbench

TBIRD_SEQ_CTRL -- requirements
Module: tbird_seq_ctrl

---
 rtl/tbird_pkg.sv | 31 +++
 rtl/tbird_step_div.sv | 28 ++
 rtl/tbird_seq_ctrl.sv | 109 ++++++++++
 tb/tb_tbird_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
// Shared encodings for the tail-light sequencer: mode values and lamp patterns.
// Latency: n/a (constants and a pure decode function only).
// Backpressure: n/a.
package tbird_pkg;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_LEFT   = 2'd1,
    M_RIGHT  = 2'd2,
    M_HAZARD = 2'd3
  } mode_t;

  // Lamp patterns, bit0 innermost lamp.
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_P1  = 3'b001;
  localparam logic [2:0] LAMP_P2  = 3'b011;
  localparam logic [2:0] LAMP_ALL = 3'b111;

  // Sweep pattern for a turn signal: lamps fill outward, then all go dark.
  function automatic logic [2:0] sweep_pat(input logic [1:0] ph);
    logic [2:0] p;
    case (ph)
      2'd1:    p = LAMP_P1;
      2'd2:    p = LAMP_P2;
      2'd3:    p = LAMP_ALL;
      default: p = LAMP_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tbird_step_div.sv
// Step divider: free-running 32-bit count 0..TICK_DIV-1 while enabled, pulses step_tick on the last count.
// Latency: step_tick is combinational from the registered count; first pulse TICK_DIV cycles after a clear.
// Backpressure: none; clr or !run force the count to 0 on the next edge.
module tbird_step_div #(
  parameter logic [31:0] TICK_DIV = 32'd25000000
) (
  input  logic cin,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic step_tick
);

  localparam logic [31:0] LAST = TICK_DIV - 32'd1;

  logic [31:0] cnt;

  // Count while running; a clear (mode change) or idle pins the count at 0.
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n)                cnt <= 32'd0;
    else if (clr || !run)      cnt <= 32'd0;
    else if (cnt == LAST)      cnt <= 32'd0;
    else                       cnt <= cnt + 32'd1;
  end

  assign step_tick = run && (cnt == LAST);

endmodule

// File: rtl/tbird_seq_ctrl.sv
// Tail-light sequencer: synchronizes switches, tracks mode/phase, drives registered lamp patterns.
// Latency: switch change to mode/lamp update is 3 rising edges (two sync flops plus state register).
// Backpressure: none; a new requested mode preempts the current step immediately.
module tbird_seq_ctrl
  import tbird_pkg::*;
#(
  parameter logic [31:0] TICK_DIV = 32'd25000000
) (
  input  logic       cin,
  input  logic       rst_n,
  input  logic       sw_left,
  input  logic       sw_right,
  input  logic       sw_hazard,
  output logic [2:0] led_l,
  output logic [2:0] led_r,
  output logic [1:0] mode,
  output logic       step_tick
);

  // Switch vectors are packed as {hazard, right, left}.
  logic [2:0] sync1, sync2;
  mode_t      mode_q, mode_d, req;
  logic [1:0] phase_q, phase_d;
  logic [2:0] led_l_d, led_r_d;
  logic       run, clr;

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= {sw_hazard, sw_right, sw_left};
      sync2 <= sync1;
    end
  end

  // Requested mode: hazard switch or both turn switches win, then single-side turns.
  always_comb begin
    req = M_IDLE;
    if (sync2[2] || (sync2[0] && sync2[1])) req = M_HAZARD;
    else if (sync2[0])                      req = M_LEFT;
    else if (sync2[1])                      req = M_RIGHT;
  end

  assign run = (mode_q != M_IDLE);
  assign clr = (req != mode_q);

  tbird_step_div #(
    .TICK_DIV (TICK_DIV)
  ) u_step_div (
    .cin       (cin),
    .rst_n     (rst_n),
    .run       (run),
    .clr       (clr),
    .step_tick (step_tick)
  );

  // Next state: a mode change restarts at phase 0 even if a step ends this cycle.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    if (clr) begin
      mode_d  = req;
      phase_d = 2'd0;
    end else if (step_tick) begin
      case (mode_q)
        M_LEFT, M_RIGHT: phase_d = phase_q + 2'd1;
        M_HAZARD:        phase_d = {1'b0, ~phase_q[0]};
        default:         phase_d = 2'd0;
      endcase
    end
  end

  // Lamp decode from the next state so the registered lamps line up with mode/phase.
  always_comb begin
    led_l_d = LAMP_OFF;
    led_r_d = LAMP_OFF;
    case (mode_d)
      M_LEFT:   led_l_d = sweep_pat(phase_d);
      M_RIGHT:  led_r_d = sweep_pat(phase_d);
      M_HAZARD: begin
        if (phase_d[0]) begin
          led_l_d = LAMP_ALL;
          led_r_d = LAMP_ALL;
        end
      end
      default: ;
    endcase
  end

  // State and lamp registers.
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= M_IDLE;
      phase_q <= 2'd0;
      led_l   <= LAMP_OFF;
      led_r   <= LAMP_OFF;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      led_l   <= led_l_d;
      led_r   <= led_r_d;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_tbird_seq_ctrl.sv
// Bench for tbird_seq_ctrl: directed scenarios with literal expectations plus randomized switching.
// Latency: outputs compared on every falling edge against a cycle-count model.
// Backpressure: n/a.
module tb_tbird_seq_ctrl;

  localparam int TD = 4;

  logic       cin = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw_left = 1'b0, sw_right = 1'b0, sw_hazard = 1'b0;
  logic [2:0] led_l, led_r;
  logic [1:0] mode;
  logic       step_tick;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  tbird_seq_ctrl #(.TICK_DIV(32'd4)) dut (
    .cin       (cin),
    .rst_n     (rst_n),
    .sw_left   (sw_left),
    .sw_right  (sw_right),
    .sw_hazard (sw_hazard),
    .led_l     (led_l),
    .led_r     (led_r),
    .mode      (mode),
    .step_tick (step_tick)
  );

  always #5 cin = ~cin;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: switch history pipeline, current mode and cycles spent in that mode.
  logic [2:0] m_s1 = 3'b0, m_s2 = 3'b0;
  int m_mode = 0;
  int m_k = 0;

  function automatic int decode(input logic [2:0] s);
    if (s[2] || (s[0] && s[1])) return 3;
    if (s[0]) return 1;
    if (s[1]) return 2;
    return 0;
  endfunction

  always @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 3'b0; m_s2 = 3'b0; m_mode = 0; m_k = 0;
    end else begin
      int r;
      r = decode(m_s2);
      if (r != m_mode) begin
        m_mode = r;
        m_k = 0;
      end else if (m_mode != 0) m_k = m_k + 1;
      else m_k = 0;
      m_s2 = m_s1;
      m_s1 = {sw_hazard, sw_right, sw_left};
    end
  end

  // Expected {mode, led_l, led_r, step_tick} from mode and elapsed cycles.
  function automatic int expected();
    int ph, pat, el, er, st;
    ph  = (m_k / TD) % ((m_mode == 3) ? 2 : 4);
    pat = (1 << ph) - 1;
    el = 0; er = 0;
    if (m_mode == 1) el = pat;
    if (m_mode == 2) er = pat;
    if (m_mode == 3 && ph == 1) begin el = 7; er = 7; end
    st = (m_mode != 0 && (m_k % TD) == TD - 1) ? 1 : 0;
    return (m_mode << 7) | (el << 4) | (er << 1) | st;
  endfunction

  always @(negedge cin) begin
    if (run_chk) chk("cycle", int'({mode, led_l, led_r, step_tick}), expected());
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge cin);
  endtask

  task automatic set_sw(input logic l, input logic r, input logic h);
    sw_left = l; sw_right = r; sw_hazard = h;
  endtask

  initial begin
    int ticks, cnt2, lit;
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b011; exp_seq[2] = 3'b111; exp_seq[3] = 3'b000;

    #2;
    chk("reset_mode", int'(mode), 0);
    chk("reset_leds", int'({led_l, led_r, step_tick}), 0);
    #21 rst_n = 1'b1;
    run_chk = 1'b1;
    cyc(3);

    // LEFT sweep: mode appears on the third edge, lamps step every TD cycles.
    set_sw(1, 0, 0);
    cyc(2);
    chk("left_not_yet", int'(mode), 0);
    cyc(1);
    chk("left_mode", int'(mode), 1);
    chk("left_phase0", int'(led_l), 0);
    ticks = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      if (step_tick) ticks++;
      if (i % 4 == 0) chk("left_seq", int'(led_l), int'(exp_seq[i/4 - 1]));
    end
    chk("left_ticks", ticks, 4);
    chk("left_led_r", int'(led_r), 0);

    // Mode change lands on the edge that would have advanced the phase.
    cyc(1);
    set_sw(0, 1, 0);
    cyc(2);
    chk("coinc_tick", int'(step_tick), 1);
    cyc(1);
    chk("coinc_mode", int'(mode), 2);
    chk("coinc_leds", int'({led_l, led_r}), 0);
    cyc(4);
    chk("coinc_phase1", int'(led_r), 1);

    // Both turn switches: hazard alternating all-off / all-on.
    set_sw(1, 1, 0);
    cyc(3);
    chk("haz_mode", int'(mode), 3);
    chk("haz_off", int'({led_l, led_r}), 0);
    cyc(4);
    chk("haz_on", int'({led_l, led_r}), 6'o77);
    cyc(4);
    chk("haz_off2", int'({led_l, led_r}), 0);

    // LEFT to RIGHT while LEFT sits in phase 2.
    set_sw(1, 0, 0);
    cyc(3);
    chk("l2r_left", int'(mode), 1);
    cyc(8);
    chk("l2r_phase2", int'(led_l), 3);
    set_sw(0, 1, 0);
    cyc(3);
    chk("l2r_mode", int'(mode), 2);
    chk("l2r_leds", int'({led_l, led_r}), 0);
    cyc(4);
    chk("l2r_step", int'(led_r), 1);
    cyc(8);
    chk("right_phase3", int'(led_r), 7);

    // Reset pulse between edges during RIGHT phase 3.
    @(posedge cin);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mode", int'(mode), 0);
    chk("arst_outs", int'({led_l, led_r, step_tick}), 0);
    #1 rst_n = 1'b1;
    cyc(3);
    chk("rel_hold", int'(mode), 0);
    cyc(1);
    chk("rel_mode", int'(mode), 2);
    chk("rel_leds", int'(led_r), 0);
    cyc(4);
    chk("rel_step", int'(led_r), 1);

    // One-cycle glitch on sw_right from IDLE.
    set_sw(0, 0, 0);
    cyc(6);
    chk("idle_mode", int'(mode), 0);
    set_sw(0, 1, 0);
    cyc(1);
    set_sw(0, 0, 0);
    cnt2 = 0; lit = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (mode == 2'd2) cnt2++;
      if ({led_l, led_r} != 6'd0 || step_tick) lit++;
    end
    chk("glitch_cycles", cnt2, 1);
    chk("glitch_lamps", lit, 0);

    // Randomized switching with occasional asynchronous reset pulses.
    for (int n = 0; n < 600; n++) begin
      set_sw(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) set_sw(0, 0, 0);
      cyc($urandom_range(1, 14));
      if ($urandom_range(0, 40) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
